// File: rtl/sys_timer_mc_pkg.sv
// -----------------------------------------------------------------------------
// sys_timer_mc_pkg
// Shared definitions for the multi-channel system timer: per-channel register
// indices, CONTROL bit positions and the prescaler width.
// Optional feature macro used by the timer files: SYS_TIMER_MC_PULSE_EN.
// -----------------------------------------------------------------------------
package sys_timer_mc_pkg;

    localparam int PS_W   = 8;
    localparam int CTRL_W = 4;

    // Register index within a channel (address[2:0])
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;

    // CONTROL bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

endpackage

// File: rtl/sys_timer_mc_ch.sv
// -----------------------------------------------------------------------------
// sys_timer_mc_ch
// One timer channel: CNT_W-bit down-counter with period, snapshot, 8-bit
// prescaler, one-shot/continuous mode and a maskable timeout flag.
// Optional macro SYS_TIMER_MC_PULSE_EN adds tick_o, a one-clock pulse on every
// timeout, independent of ITO and STATUS writes.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   wr_i          write strobe for this channel (already decoded)
//   reg_i         register index within the channel
//   wdata_i       write data
//   rdata_o       combinational read data for reg_i
//   irq_o         TO & ITO
//   tick_o        timeout pulse (only with SYS_TIMER_MC_PULSE_EN)
// -----------------------------------------------------------------------------
module sys_timer_mc_ch
    import sys_timer_mc_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h001E847F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_i,
    input  logic [2:0]  reg_i,
    input  logic [15:0] wdata_i,
    output logic [15:0] rdata_o,
    output logic        irq_o
`ifdef SYS_TIMER_MC_PULSE_EN
    ,
    output logic        tick_o
`endif
);

    localparam int               HI_W       = CNT_W - 16;
    localparam logic [CNT_W-1:0] RST_PERIOD = RESET_PERIOD[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PS_W-1:0]  PS_ONE     = {{(PS_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  snap_q, snap_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [PS_W-1:0]   pscnt_q, pscnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              run_q, run_d;
    logic              to_q, to_d;
    logic              reload_q, reload_d;
    logic              tick;
    logic              to_set;
    logic [15:0]       period_hi;
    logic [15:0]       snap_hi;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        snap_d   = snap_q;
        ps_d     = ps_q;
        pscnt_d  = pscnt_q;
        ctrl_d   = ctrl_q;
        run_d    = run_q;
        to_d     = to_q;
        reload_d = 1'b0;
        to_set   = 1'b0;
        tick     = run_q && (pscnt_q == ps_q);

        if (run_q) begin
            pscnt_d = tick ? '0 : pscnt_q + PS_ONE;
        end

        // A pending force-reload (from a PERIOD write last cycle) overrides
        // any counter step this cycle.
        if (reload_q) begin
            cnt_d   = period_q;
            run_d   = 1'b0;
            pscnt_d = '0;
        end else if (tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                cnt_d  = period_q;
                to_set = 1'b1;
                if (!ctrl_q[CTRL_CONT]) begin
                    run_d = 1'b0;
                end
            end
        end

        if (wr_i) begin
            case (reg_i)
                REG_STATUS: to_d = 1'b0;
                REG_CONTROL: begin
                    ctrl_d = wdata_i[CTRL_W-1:0];
                    // START has priority over STOP
                    if (wdata_i[CTRL_START]) begin
                        run_d   = 1'b1;
                        pscnt_d = '0;
                    end else if (wdata_i[CTRL_STOP]) begin
                        run_d = 1'b0;
                    end
                end
                REG_PERIOD_L: begin
                    period_d[15:0] = wdata_i;
                    reload_d       = 1'b1;
                    run_d          = 1'b0;
                end
                REG_PERIOD_H: begin
                    period_d[CNT_W-1:16] = wdata_i[HI_W-1:0];
                    reload_d             = 1'b1;
                    run_d                = 1'b0;
                end
                REG_SNAP_L,
                REG_SNAP_H: snap_d = cnt_q;
                REG_PRESCALE: begin
                    ps_d    = wdata_i[PS_W-1:0];
                    pscnt_d = '0;
                end
                default: ;
            endcase
        end

        // A timeout in the same cycle as a STATUS write keeps TO set
        if (to_set) begin
            to_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= RST_PERIOD;
            period_q <= RST_PERIOD;
            snap_q   <= '0;
            ps_q     <= '0;
            pscnt_q  <= '0;
            ctrl_q   <= '0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            snap_q   <= snap_d;
            ps_q     <= ps_d;
            pscnt_q  <= pscnt_d;
            ctrl_q   <= ctrl_d;
            run_q    <= run_d;
            to_q     <= to_d;
            reload_q <= reload_d;
        end
    end

    // High halves are zero-extended so unused upper bits read 0
    always_comb begin
        period_hi            = '0;
        period_hi[HI_W-1:0]  = period_q[CNT_W-1:16];
        snap_hi              = '0;
        snap_hi[HI_W-1:0]    = snap_q[CNT_W-1:16];
    end

    always_comb begin
        rdata_o = '0;
        case (reg_i)
            REG_STATUS:   rdata_o = {14'd0, run_q, to_q};
            REG_CONTROL:  rdata_o = {{(16-CTRL_W){1'b0}}, ctrl_q};
            REG_PERIOD_L: rdata_o = period_q[15:0];
            REG_PERIOD_H: rdata_o = period_hi;
            REG_SNAP_L:   rdata_o = snap_q[15:0];
            REG_SNAP_H:   rdata_o = snap_hi;
            REG_PRESCALE: rdata_o = {{(16-PS_W){1'b0}}, ps_q};
            default:      rdata_o = '0;
        endcase
    end

    assign irq_o = to_q & ctrl_q[CTRL_ITO];

`ifdef SYS_TIMER_MC_PULSE_EN
    logic tick_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= to_set;
        end
    end

    assign tick_o = tick_q;
`else
    // No timeout pulse output in this build; to_set only feeds TO.
`endif

endmodule

// File: rtl/sys_timer_mc.sv
// -----------------------------------------------------------------------------
// sys_timer_mc
// Multi-channel Avalon-MM interval timer. N_CH independent channels, each a
// sys_timer_mc_ch instance; this level decodes {channel, reg} addresses,
// registers read data (1-cycle latency) and ORs the channel interrupts.
// Optional macro SYS_TIMER_MC_PULSE_EN adds tick_out[N_CH-1:0].
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   address       {channel, reg[2:0]}
//   chipselect    slave select
//   write_n       active-low write
//   writedata     16-bit write data
//   readdata      registered read data, 0 when not reading
//   irq           OR of irq_vec
//   irq_vec       per-channel TO & ITO
//   tick_out      per-channel timeout pulse (only with SYS_TIMER_MC_PULSE_EN)
// -----------------------------------------------------------------------------
module sys_timer_mc #(
    parameter int          N_CH         = 2,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] RESET_PERIOD = 32'h001E847F,
    parameter int          ADDR_W       = $clog2(N_CH) + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic [N_CH-1:0]   irq_vec
`ifdef SYS_TIMER_MC_PULSE_EN
    ,
    output logic [N_CH-1:0]   tick_out
`endif
);

    // One spare bit so the channel field exists even for N_CH=1
    localparam int CH_IDX_W = ADDR_W - 2;

    logic [CH_IDX_W-1:0] ch_sel;
    logic                wr_strobe;
    logic                rd_strobe;
    logic [N_CH-1:0]     wr_en;
    logic [15:0]         ch_rdata [N_CH];
    logic [15:0]         rd_mux;
    logic [15:0]         readdata_q;
    logic [15:0]         readdata_d;

    assign ch_sel    = CH_IDX_W'({1'b0, address} >> 3);
    assign wr_strobe = chipselect && !write_n;
    assign rd_strobe = chipselect && write_n;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign wr_en[i] = wr_strobe && (ch_sel == CH_IDX_W'(i));

        sys_timer_mc_ch #(
            .CNT_W        (CNT_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_i    (wr_en[i]),
            .reg_i   (address[2:0]),
            .wdata_i (writedata),
            .rdata_o (ch_rdata[i]),
            .irq_o   (irq_vec[i])
`ifdef SYS_TIMER_MC_PULSE_EN
            ,
            .tick_o  (tick_out[i])
`endif
        );
    end

    // Channel indices with no instance fall through to 0
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == CH_IDX_W'(i)) begin
                rd_mux = ch_rdata[i];
            end
        end
    end

    assign readdata_d = rd_strobe ? rd_mux : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;

endmodule

// File: doc/sys_timer_mc.md
# sys_timer_mc

Multi-channel, parametrised interval timer for the SS-OCT Nios II system, replacing the single-channel Avalon-MM system timer. Provides N_CH independent down-counters of CNT_W bits, each with period, snapshot, 8-bit prescaler, one-shot/continuous mode and a maskable timeout interrupt. Sits on the 16-bit Avalon-MM peripheral bus and drives one combined IRQ line plus a per-channel IRQ vector for acquisition sequencing.

## Interface
- N_CH, 2: number of timer channels, 1..8
- CNT_W, 32: counter width, 17..32; period and snapshot are split into 16-bit low/high halves
- RESET_PERIOD, 32'h001E847F: period and counter value after reset, truncated to CNT_W
- ADDR_W, $clog2(N_CH)+3: derived address width
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  ADDR_W  {channel, reg[2:0]}
- chipselect  in  1  Avalon slave select
- write_n  in  1  active-low write
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq  out  1  OR of irq_vec
- irq_vec  out  N_CH  per channel: TO & ITO

## Operation
- Per-channel registers (reg index):
  - 0 STATUS: {RUN, TO}. Any write clears TO.
  - 1 CONTROL: [3] STOP, [2] START, [1] CONT, [0] ITO, stored as 4 bits. Write START=1 sets RUN; STOP=1 clears RUN; START wins if both are set.
  - 2/3 PERIOD_L/PERIOD_H: write loads the half, then force-reloads the counter next cycle and clears RUN. Unused PERIOD_H bits above CNT_W-16 read 0.
  - 4/5 SNAP_L/SNAP_H: write to either captures the live counter into the snapshot; read returns the snapshot.
  - 6 PRESCALE: [7:0] PS. The counter tick fires every PS+1 clocks. Write clears the prescale counter.
  - 7: reserved, reads 0, writes ignored.
- Counter step occurs when RUN=1 and the tick fires:
  - counter≠0: decrement.
  - counter=0: reload PERIOD, set TO, and clear RUN if CONT=0.
- Period P gives a timeout every (P+1)·(PS+1) clocks. P=0 in continuous mode gives TO on every tick.
- TO set and a STATUS write in the same cycle: set wins.
- START while RUN=1: no effect on the counter.
- The prescale counter restarts on START and on force-reload.
- Reads to channel indices ≥ N_CH return 0. Writes to them are ignored.

## Timing
- Reset values: readdata=0, irq=0, irq_vec=0, RUN=0, TO=0, CONTROL=0, PS=0, snapshots=0, counter=PERIOD=RESET_PERIOD.
- Read latency: 1 cycle. readdata reflects the address from the previous cycle.
- Write effects are visible to a read issued the next cycle.
- RUN goes high 1 cycle after the START write. The first decrement occurs on the first tick after that: PS+1 clocks later.
- Force-reload: counter=PERIOD 2 cycles after the PERIOD write, with RUN=0.
- TO and irq_vec rise 1 cycle after the zero-reload tick.
- irq is combinational from irq_vec.
- Asynchronous reset mid-count returns every state to its reset value immediately.

## Configuration
- SYS_TIMER_MC_PULSE_EN defined:
  - Adds output port tick_out[N_CH-1:0], a one-clock pulse per channel, coincident with the TO set edge.
  - The pulse is unmasked by ITO and unaffected by STATUS writes.
  - Reset value 0.
- SYS_TIMER_MC_PULSE_EN undefined: the port and its logic are absent. Register behaviour is identical in both cases.

## Structure
- Package sys_timer_mc_pkg holds:
  - register index localparams: REG_STATUS..REG_PRESCALE
  - CONTROL bit positions
  - PS_W=8
- Sub-module sys_timer_mc_ch: one channel containing counter, prescaler, RUN/TO, period, snapshot and control.
  - Instantiated N_CH times in a generate loop.
  - The top level holds address decode, the read mux and the IRQ OR.

## Test plan
- Reset: read ch0 PERIOD_L/H -> 0x847F/0x001E; STATUS -> 0; irq=0.
- Ch0 PERIOD=9, PS=0, CONTROL=0x7 -> TO every 10 clocks, irq high, STATUS reads 0x3. STATUS write -> irq low within 1 cycle.
- Ch1 PERIOD=4, PS=3, CONTROL=0x5 (one-shot) -> single TO after 20 clocks. RUN=0 and counter=4 afterwards.
- Running ch0: write PERIOD_L=100 -> RUN clears, and counter=100 two cycles after the write. Snapshot write then SNAP_L read -> 100.
- STATUS write in the same cycle as a timeout -> TO remains 1. CONTROL=0xC -> RUN=1.
- With SYS_TIMER_MC_PULSE_EN, ITO=0 -> tick_out pulses 1 clock per timeout while irq stays 0.
